// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
//
// Merges the L1 instruction-cache and data-cache request channels onto one
// downstream memory channel and routes each memory response back to the
// cache that issued the matching request.
//
// Request path:
//   - Combinational round-robin arbiter picks at most one winner per cycle.
//   - The winner is registered into a one-entry output slot (mem_req_*).
//   - The source of every accepted request (0 = IC, 1 = DC) is pushed into an
//     in-order tag FIFO, which also bounds the number of in-flight requests.
//
// Response path:
//   - Memory responses come back strictly in request order, so the FIFO head
//     tag names the destination cache. Read data goes to both ports; only the
//     selected port sees valid.
//   - A response arriving with no outstanding tag is dropped and latches the
//     sticky protocol_err_o flag until reset.
//
// Handshake rule for every channel in this block: a transfer happens on a
// rising clock edge where valid and ready are both high. A source that raises
// valid holds it and its payload stable until that edge. ready may be high
// while valid is low; that carries no meaning.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   ic_req_*                   icache request (read-only, address only)
//   ic_rsp_*                   icache response (read data)
//   dc_req_*                   dcache request (address, write, wdata, strb)
//   dc_rsp_*                   dcache response (read data)
//   mem_req_*                  registered downstream request slot
//   mem_rsp_*                  downstream response, in request order
//   outstanding_o              tag FIFO occupancy (in-flight requests)
//   protocol_err_o             sticky: response seen with FIFO empty
// -----------------------------------------------------------------------------
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,

  input  logic                               ic_req_valid_i,
  output logic                               ic_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]              ic_req_addr_i,
  output logic                               ic_rsp_valid_o,
  input  logic                               ic_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]              ic_rsp_rdata_o,

  input  logic                               dc_req_valid_i,
  output logic                               dc_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]              dc_req_addr_i,
  input  logic                               dc_req_write_i,
  input  logic [DATA_WIDTH-1:0]              dc_req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            dc_req_strb_i,
  output logic                               dc_rsp_valid_o,
  input  logic                               dc_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]              dc_rsp_rdata_o,

  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
  output logic                               mem_req_write_o,
  output logic [DATA_WIDTH-1:0]              mem_req_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mem_req_strb_o,
  input  logic                               mem_rsp_valid_i,
  output logic                               mem_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]              mem_rsp_rdata_i,

  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               protocol_err_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;

  localparam logic                 TAG_IC  = 1'b0;
  localparam logic                 TAG_DC  = 1'b1;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    r_last_grant;     // TAG_IC / TAG_DC of last accept

  logic                    r_req_valid;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic                    r_req_write;
  logic [DATA_WIDTH-1:0]   r_req_wdata;
  logic [STRB_WIDTH-1:0]   r_req_strb;

  logic                    r_tag_mem [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]    r_wr_ptr;
  logic [PTR_WIDTH-1:0]    r_rd_ptr;
  logic [CNT_WIDTH-1:0]    r_count;

  logic                    r_protocol_err;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_slot_free;
  logic w_credit;
  logic w_can_accept;
  logic w_grant_dc;
  logic w_accept;
  logic w_push;

  // The slot can take a new entry when it is empty or is handing its current
  // entry downstream this cycle, which gives one issue per cycle.
  assign w_slot_free  = !r_req_valid || mem_req_ready_i;

  // Credit uses the registered count only: a pop this cycle does not make
  // room for a push this cycle. This keeps the ready path free of the
  // response handshake.
  assign w_credit     = (r_count < MAX_CNT);
  assign w_can_accept = w_slot_free && w_credit;

  // DC wins when it is the only requester, or on a tie when IC had the last
  // grant. With no requester the default pick is IC.
  assign w_grant_dc   = dc_req_valid_i &&
                        (!ic_req_valid_i || (r_last_grant == TAG_IC));

  assign ic_req_ready_o = w_can_accept && !w_grant_dc;
  assign dc_req_ready_o = w_can_accept &&  w_grant_dc;

  assign w_accept = (ic_req_valid_i && ic_req_ready_o) ||
                    (dc_req_valid_i && dc_req_ready_o);
  assign w_push   = w_accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= TAG_IC;
    end else if (w_accept) begin
      r_last_grant <= w_grant_dc ? TAG_DC : TAG_IC;
    end
  end

  // ---------------------------------------------------------------------------
  // Output request slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_write <= 1'b0;
      r_req_wdata <= '0;
      r_req_strb  <= '0;
    end else if (w_accept) begin
      r_req_valid <= 1'b1;
      if (w_grant_dc) begin
        r_req_addr  <= dc_req_addr_i;
        r_req_write <= dc_req_write_i;
        r_req_wdata <= dc_req_wdata_i;
        r_req_strb  <= dc_req_strb_i;
      end else begin
        // The icache channel is read-only; write fields are forced to zero.
        r_req_addr  <= ic_req_addr_i;
        r_req_write <= 1'b0;
        r_req_wdata <= '0;
        r_req_strb  <= '0;
      end
    end else if (mem_req_ready_i) begin
      // Handshake (or idle slot) with no reload: slot becomes empty.
      r_req_valid <= 1'b0;
    end
  end

  assign mem_req_valid_o = r_req_valid;
  assign mem_req_addr_o  = r_req_addr;
  assign mem_req_write_o = r_req_write;
  assign mem_req_wdata_o = r_req_wdata;
  assign mem_req_strb_o  = r_req_strb;

  // ---------------------------------------------------------------------------
  // Tag FIFO and response routing
  // ---------------------------------------------------------------------------
  logic w_fifo_empty;
  logic w_head_tag;
  logic w_pop;
  logic w_spurious;

  assign w_fifo_empty = (r_count == '0);
  assign w_head_tag   = r_tag_mem[r_rd_ptr];

  assign ic_rsp_valid_o = mem_rsp_valid_i && !w_fifo_empty && (w_head_tag == TAG_IC);
  assign dc_rsp_valid_o = mem_rsp_valid_i && !w_fifo_empty && (w_head_tag == TAG_DC);
  assign ic_rsp_rdata_o = mem_rsp_rdata_i;
  assign dc_rsp_rdata_o = mem_rsp_rdata_i;

  // With nothing outstanding the response has no owner: accept and drop it
  // so the downstream side never stalls on a response nobody will take.
  always_comb begin
    mem_rsp_ready_o = 1'b1;
    if (!w_fifo_empty) begin
      mem_rsp_ready_o = (w_head_tag == TAG_DC) ? dc_rsp_ready_i : ic_rsp_ready_i;
    end
  end

  assign w_pop      = mem_rsp_valid_i && mem_rsp_ready_o && !w_fifo_empty;
  assign w_spurious = mem_rsp_valid_i && w_fifo_empty;

  // Tag storage needs no reset: entries are only read when the count says
  // they were written since the last reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_dc ? TAG_DC : TAG_IC;
    end
  end

  // Pointers wrap naturally because MAX_OUTSTANDING is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_protocol_err <= 1'b0;
    end else if (w_spurious) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1_mem_arbiter
//
// Directed bench for l1_mem_arbiter. A cycle-by-cycle vector table covers a
// single icache read, the post-reset tie sequence, full-FIFO credit with a
// concurrent pop and response backpressure. Hand-written sequences cover the
// multi-cycle request backpressure hold and the spurious response / mid-stream
// reset case.
//
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_l1_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_rsp_valid;
  logic        ic_rsp_ready;
  logic [31:0] ic_rsp_rdata;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic        dc_req_write;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_strb;
  logic        dc_rsp_valid;
  logic        dc_rsp_ready;
  logic [31:0] dc_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_strb;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int checks;
  int errors;

  l1_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ic_req_valid_i (ic_req_valid),
    .ic_req_ready_o (ic_req_ready),
    .ic_req_addr_i  (ic_req_addr),
    .ic_rsp_valid_o (ic_rsp_valid),
    .ic_rsp_ready_i (ic_rsp_ready),
    .ic_rsp_rdata_o (ic_rsp_rdata),
    .dc_req_valid_i (dc_req_valid),
    .dc_req_ready_o (dc_req_ready),
    .dc_req_addr_i  (dc_req_addr),
    .dc_req_write_i (dc_req_write),
    .dc_req_wdata_i (dc_req_wdata),
    .dc_req_strb_i  (dc_req_strb),
    .dc_rsp_valid_o (dc_rsp_valid),
    .dc_rsp_ready_i (dc_rsp_ready),
    .dc_rsp_rdata_o (dc_rsp_rdata),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_write_o(mem_req_write),
    .mem_req_wdata_o(mem_req_wdata),
    .mem_req_strb_o (mem_req_strb),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_ready_o(mem_rsp_ready),
    .mem_rsp_rdata_i(mem_rsp_rdata),
    .outstanding_o  (outstanding),
    .protocol_err_o (protocol_err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst           = 1'b0;
    ic_req_valid  = 1'b0;
    ic_req_addr   = '0;
    dc_req_valid  = 1'b0;
    dc_req_addr   = '0;
    dc_req_write  = 1'b0;
    dc_req_wdata  = '0;
    dc_req_strb   = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    ic_rsp_ready  = 1'b1;
    dc_rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rst;
    logic        ic_v;
    logic [31:0] ic_addr;
    logic        dc_v;
    logic [31:0] dc_addr;
    logic        dc_w;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_strb;
    logic        mq_rdy;
    logic        mr_v;
    logic [31:0] mr_data;
    logic        ic_rr;
    logic        dc_rr;
    logic        chk_rdy;   // compare request readies this cycle
    logic        e_ic_rdy;
    logic        e_dc_rdy;
    logic        e_mq_v;
    logic [31:0] e_mq_addr;
    logic        e_mq_w;
    logic [31:0] e_mq_wdata;
    logic [3:0]  e_mq_strb;
    logic        e_ic_rv;
    logic        e_dc_rv;
    logic        e_mr_rdy;
    logic [2:0]  e_out;
    logic        e_perr;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    // Field order:
    // rst ic_v ic_addr dc_v dc_addr dc_w dc_wdata dc_strb mq_rdy mr_v mr_data ic_rr dc_rr chk_rdy |
    // e_ic_rdy e_dc_rdy e_mq_v e_mq_addr e_mq_w e_mq_wdata e_mq_strb e_ic_rv e_dc_rv e_mr_rdy e_out e_perr

    // Single icache read of 0x100, answered with 0xDEADBEEF.
    vecs[0]  = '{0,1,32'h100,0,32'h0,0,32'h0,4'h0,1,0,32'h0,1,1,1,
                 1,0,0,32'h0,0,32'h0,4'h0,0,0,1,3'd0,0};
    vecs[1]  = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,1,0,32'h0,1,1,0,
                 0,0,1,32'h100,0,32'h0,4'h0,0,0,1,3'd1,0};
    vecs[2]  = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,1,1,32'hDEADBEEF,1,1,0,
                 0,0,0,32'h0,0,32'h0,4'h0,1,0,1,3'd1,0};
    vecs[3]  = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,1,0,32'h0,1,1,0,
                 0,0,0,32'h0,0,32'h0,4'h0,0,0,1,3'd0,0};
    // Reset applied at the end of this cycle.
    vecs[4]  = '{1,0,32'h0,0,32'h0,0,32'h0,4'h0,1,0,32'h0,1,1,0,
                 0,0,0,32'h0,0,32'h0,4'h0,0,0,1,3'd0,0};
    // Tie after reset: DC, IC, DC, IC, then no credit.
    vecs[5]  = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 0,1,0,32'h0,0,32'h0,4'h0,0,0,1,3'd0,0};
    vecs[6]  = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 1,0,1,32'h20,1,32'hCAFE0001,4'hC,0,0,1,3'd1,0};
    vecs[7]  = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 0,1,1,32'h10,0,32'h0,4'h0,0,0,1,3'd2,0};
    vecs[8]  = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 1,0,1,32'h20,1,32'hCAFE0001,4'hC,0,0,1,3'd3,0};
    vecs[9]  = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 0,0,1,32'h10,0,32'h0,4'h0,0,0,1,3'd4,0};
    vecs[10] = '{0,1,32'h10,1,32'h20,1,32'hCAFE0001,4'hC,1,0,32'h0,1,1,1,
                 0,0,0,32'h0,0,32'h0,4'h0,0,0,1,3'd4,0};
    // Full plus pop: no accept in the pop cycle, accept the next cycle.
    vecs[11] = '{0,0,32'h0,1,32'h30,0,32'h0,4'h0,1,1,32'hA5A5A5A5,1,1,1,
                 0,0,0,32'h0,0,32'h0,4'h0,0,1,1,3'd4,0};
    vecs[12] = '{0,0,32'h0,1,32'h30,0,32'h0,4'h0,1,0,32'h0,1,1,1,
                 0,1,0,32'h0,0,32'h0,4'h0,0,0,1,3'd3,0};
    vecs[13] = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,0,0,32'h0,1,1,0,
                 0,0,1,32'h30,0,32'h0,4'h0,0,0,1,3'd4,0};
    // Drain the IC head, then hold a DC-headed response off.
    vecs[14] = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,0,1,32'h12345678,1,1,0,
                 0,0,1,32'h30,0,32'h0,4'h0,1,0,1,3'd4,0};
    vecs[15] = '{0,0,32'h0,1,32'h40,0,32'h0,4'h0,0,1,32'h0BADF00D,1,0,1,
                 0,0,1,32'h30,0,32'h0,4'h0,0,1,0,3'd3,0};
    vecs[16] = '{0,0,32'h0,0,32'h0,0,32'h0,4'h0,0,1,32'h0BADF00D,1,0,0,
                 0,0,1,32'h30,0,32'h0,4'h0,0,1,0,3'd3,0};
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int hs;
    checks = 0;
    errors = 0;
    drive_idle();
    #1;

    // Reset state.
    do_reset();
    sample();
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_addr",  mem_req_addr,       32'h0);
    check("rst_mem_req_write", 32'(mem_req_write), 32'd0);
    check("rst_mem_req_wdata", mem_req_wdata,      32'h0);
    check("rst_mem_req_strb",  32'(mem_req_strb),  32'd0);
    check("rst_outstanding",   32'(outstanding),   32'd0);
    check("rst_protocol_err",  32'(protocol_err),  32'd0);
    check("rst_ic_rsp_valid",  32'(ic_rsp_valid),  32'd0);
    check("rst_dc_rsp_valid",  32'(dc_rsp_valid),  32'd0);
    tick();

    // Table-driven cycles.
    for (int i = 0; i < NVEC; i++) begin
      rst           = vecs[i].rst;
      ic_req_valid  = vecs[i].ic_v;
      ic_req_addr   = vecs[i].ic_addr;
      dc_req_valid  = vecs[i].dc_v;
      dc_req_addr   = vecs[i].dc_addr;
      dc_req_write  = vecs[i].dc_w;
      dc_req_wdata  = vecs[i].dc_wdata;
      dc_req_strb   = vecs[i].dc_strb;
      mem_req_ready = vecs[i].mq_rdy;
      mem_rsp_valid = vecs[i].mr_v;
      mem_rsp_rdata = vecs[i].mr_data;
      ic_rsp_ready  = vecs[i].ic_rr;
      dc_rsp_ready  = vecs[i].dc_rr;
      sample();
      if (vecs[i].chk_rdy) begin
        check($sformatf("v%0d_ic_req_ready", i), 32'(ic_req_ready), 32'(vecs[i].e_ic_rdy));
        check($sformatf("v%0d_dc_req_ready", i), 32'(dc_req_ready), 32'(vecs[i].e_dc_rdy));
      end
      check($sformatf("v%0d_mem_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].e_mq_v));
      if (vecs[i].e_mq_v) begin
        check($sformatf("v%0d_mem_req_addr", i),  mem_req_addr,        vecs[i].e_mq_addr);
        check($sformatf("v%0d_mem_req_write", i), 32'(mem_req_write),  32'(vecs[i].e_mq_w));
        check($sformatf("v%0d_mem_req_wdata", i), mem_req_wdata,       vecs[i].e_mq_wdata);
        check($sformatf("v%0d_mem_req_strb", i),  32'(mem_req_strb),   32'(vecs[i].e_mq_strb));
      end
      check($sformatf("v%0d_ic_rsp_valid", i),  32'(ic_rsp_valid),  32'(vecs[i].e_ic_rv));
      check($sformatf("v%0d_dc_rsp_valid", i),  32'(dc_rsp_valid),  32'(vecs[i].e_dc_rv));
      check($sformatf("v%0d_mem_rsp_ready", i), 32'(mem_rsp_ready), 32'(vecs[i].e_mr_rdy));
      check($sformatf("v%0d_outstanding", i),   32'(outstanding),   32'(vecs[i].e_out));
      check($sformatf("v%0d_protocol_err", i),  32'(protocol_err),  32'(vecs[i].e_perr));
      if (vecs[i].mr_v) begin
        check($sformatf("v%0d_ic_rsp_rdata", i), ic_rsp_rdata, vecs[i].mr_data);
        check($sformatf("v%0d_dc_rsp_rdata", i), dc_rsp_rdata, vecs[i].mr_data);
      end
      tick();
    end

    // Request backpressure: dcache write held in the slot for 5 cycles.
    do_reset();
    dc_req_valid  = 1'b1;
    dc_req_addr   = 32'h200;
    dc_req_write  = 1'b1;
    dc_req_wdata  = 32'h11223344;
    dc_req_strb   = 4'hF;
    mem_req_ready = 1'b0;
    sample();
    check("bp_first_dc_ready", 32'(dc_req_ready), 32'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      sample();
      check($sformatf("bp%0d_valid", c), 32'(mem_req_valid), 32'd1);
      check($sformatf("bp%0d_addr", c),  mem_req_addr,       32'h200);
      check($sformatf("bp%0d_write", c), 32'(mem_req_write), 32'd1);
      check($sformatf("bp%0d_wdata", c), mem_req_wdata,      32'h11223344);
      check($sformatf("bp%0d_strb", c),  32'(mem_req_strb),  32'hF);
      check($sformatf("bp%0d_dc_ready", c), 32'(dc_req_ready), 32'd0);
      check($sformatf("bp%0d_outstanding", c), 32'(outstanding), 32'd1);
      tick();
    end
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      if (mem_req_valid && mem_req_ready) hs++;
      tick();
    end
    check("bp_handshakes", 32'(hs), 32'd1);
    sample();
    check("bp_end_outstanding", 32'(outstanding), 32'd1);
    tick();

    // Spurious response, then reset with two requests in flight.
    // last_grant is DC here, so a tie right after reset shows the reset value.
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h55AA55AA;
    sample();
    check("sp_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    check("sp_ic_rsp_valid",  32'(ic_rsp_valid),  32'd0);
    check("sp_dc_rsp_valid",  32'(dc_rsp_valid),  32'd0);
    check("sp_err_before",    32'(protocol_err),  32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("sp%0d_err_sticky", c), 32'(protocol_err), 32'd1);
      tick();
    end
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h400;
    dc_req_valid = 1'b1;
    dc_req_addr  = 32'h500;
    dc_req_write = 1'b0;
    dc_req_wdata = '0;
    dc_req_strb  = '0;
    sample();
    check("sp_tie_dc_ready", 32'(dc_req_ready), 32'd1);
    check("sp_tie_ic_ready", 32'(ic_req_ready), 32'd0);
    tick();
    sample();
    check("sp_tie2_ic_ready", 32'(ic_req_ready), 32'd1);
    check("sp_tie2_dc_ready", 32'(dc_req_ready), 32'd0);
    tick();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    rst          = 1'b1;
    sample();
    check("sp_pre_rst_outstanding", 32'(outstanding),   32'd2);
    check("sp_pre_rst_err",         32'(protocol_err),  32'd1);
    check("sp_pre_rst_valid",       32'(mem_req_valid), 32'd1);
    tick();
    rst = 1'b0;
    sample();
    check("sp_post_rst_outstanding", 32'(outstanding),   32'd0);
    check("sp_post_rst_valid",       32'(mem_req_valid), 32'd0);
    check("sp_post_rst_err",         32'(protocol_err),  32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Arbitrates the per-core L1 instruction-cache and data-cache request channels onto a single downstream memory request/response channel.
- Sits between the core subsystem's L1 caches and the memory wrapper or L2 port.
- Registers the granted request into a one-entry output slot.
- Tracks outstanding transactions in an in-order tag FIFO and routes each memory response back to the originating cache.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, write/read data width. Strobe width = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, tag FIFO depth and maximum in-flight transactions. Power of 2, ≥2.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ic_req_valid_i  in  1  icache request valid.
- ic_req_ready_o  out  1  icache request accepted.
- ic_req_addr_i  in  ADDR_WIDTH  icache address; read-only channel, write forced 0.
- ic_rsp_valid_o  out  1  icache response valid.
- ic_rsp_ready_i  in  1  icache can take response.
- ic_rsp_rdata_o  out  DATA_WIDTH  icache read data.
- dc_req_valid_i  in  1  dcache request valid.
- dc_req_ready_o  out  1  dcache request accepted.
- dc_req_addr_i  in  ADDR_WIDTH  dcache address.
- dc_req_write_i  in  1  1 = write.
- dc_req_wdata_i  in  DATA_WIDTH  write data.
- dc_req_strb_i  in  DATA_WIDTH/8  byte strobes.
- dc_rsp_valid_o  out  1  dcache response valid.
- dc_rsp_ready_i  in  1  dcache can take response.
- dc_rsp_rdata_o  out  DATA_WIDTH  dcache read data.
- mem_req_valid_o  out  1  downstream request valid (registered).
- mem_req_ready_i  in  1  downstream accepts.
- mem_req_addr_o, mem_req_write_o, mem_req_wdata_o, mem_req_strb_o  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  registered request fields.
- mem_rsp_valid_i  in  1  downstream response valid; responses return strictly in request order.
- mem_rsp_ready_o  out  1  response accepted.
- mem_rsp_rdata_i  in  DATA_WIDTH  response data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy.
- protocol_err_o  out  1  sticky: response received with no outstanding tag.

Behaviour:
- Reset (rst_i=1 at clock edge, any time, including mid-transaction):
  - mem_req_valid_o=0; all request fields 0.
  - FIFO empty; outstanding_o=0; protocol_err_o=0.
  - last_grant=IC, so dcache wins the first tie.
  - In-flight transactions are discarded; no responses are routed until new requests are accepted.
- Slot free: slot_free = !mem_req_valid_o || mem_req_ready_i.
- Credit: credit = (outstanding_o < MAX_OUTSTANDING), using the registered count. A pop in the same cycle does NOT free credit for a push, so at full the push waits one cycle.
- Arbitration (combinational, one winner per cycle):
  - Only one valid: that one wins.
  - Both valid: the requester ≠ last_grant wins (round-robin).
  - Winner's ready_o = slot_free && credit; loser's ready_o = 0.
  - Both ready_o = 0 when no credit or no free slot.
- Accept (winner valid && ready):
  - Load the output slot next cycle (latency 1: accept at edge N, mem_req_valid_o high after N).
  - Push source tag (0=IC, 1=DC) into the FIFO.
  - Update last_grant.
  - Icache loads write=0, wdata=0, strb=0.
- Output slot:
  - Holds all fields stable while mem_req_valid_o && !mem_req_ready_i.
  - Clears on handshake unless reloaded the same cycle; back-to-back issue is 1 per cycle.
- Response routing (combinational):
  - Head tag selects the destination: rsp_valid_o = mem_rsp_valid_i && FIFO non-empty && tag match; rdata is passed through to both ports.
  - mem_rsp_ready_o = selected port's rsp_ready_i.
  - Pop on mem_rsp_valid_i && mem_rsp_ready_o.
- Empty-FIFO response: mem_rsp_ready_o=1 (drop), no port valid, protocol_err_o set until reset.
- Occupancy: push+pop in the same cycle leaves outstanding_o unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- Every request, read or write, yields exactly one response.

Test Plan:
- Single icache read: ic addr 0x100 → mem_req_valid_o 1 cycle later, addr 0x100, write=0; response 0xDEADBEEF → ic_rsp_valid_o with 0xDEADBEEF, dc_rsp_valid_o stays 0, outstanding 1→0.
- Tie after reset: both valid every cycle, mem_req_ready_i=1, responses held off → grants DC, IC, DC, IC; after 4 accepts both ready_o=0 and outstanding_o=4.
- Backpressure: mem_req_ready_i=0 for 5 cycles with dcache write 0x200/0x11223344/strb 0xF → all fields stable, no further accepts; ready high → one handshake only.
- Full plus pop: outstanding=4, response popped the same cycle a request is pending → no accept that cycle, accept next cycle, outstanding ends at 4.
- Response backpressure: head tag DC, dc_rsp_ready_i=0 → mem_rsp_ready_o=0, no pop; ic_rsp_valid_o stays 0 throughout.
- Spurious response plus reset: mem_rsp_valid_i with FIFO empty → protocol_err_o=1 sticky; rst_i with 2 outstanding → next cycle outstanding_o=0, mem_req_valid_o=0, protocol_err_o=0.
